// File: rtl/vga_fb_pkg.sv
// Shared constants, FSM state type and saturating counter helpers for the
// plot framebuffer.
package vga_fb_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int ADDR_W    = 15;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vga_plot_framebuffer_if.sv
// Bus bundle between plotting user logic (master) and the framebuffer (slave).
//
// Handshake semantics: there is no ready/backpressure anywhere. plot is a
// strobe sampled every clock together with VGA_X/VGA_Y/VGA_COLOR. rd_req is
// accepted on every clock it is high; each accepted request produces exactly
// one rd_valid pulse a fixed two edges later, in request order. clear_req is a
// request only looked at while busy is low.
interface vga_plot_framebuffer_if #(parameter int COLOR_BITS = 3) ();
  import vga_fb_pkg::*;

  logic [X_W-1:0]        VGA_X;
  logic [Y_W-1:0]        VGA_Y;
  logic [COLOR_BITS-1:0] VGA_COLOR;
  logic                  plot;
  logic                  clear_req;
  logic [COLOR_BITS-1:0] clear_color;
  logic                  rd_req;
  logic [X_W-1:0]        rd_x;
  logic [Y_W-1:0]        rd_y;
  logic                  rd_valid;
  logic [COLOR_BITS-1:0] rd_color;
  logic                  busy;
  logic [15:0]           plot_count;
  logic [7:0]            drop_count;
  fb_state_t             state_dbg;

  modport master (
    output VGA_X, VGA_Y, VGA_COLOR, plot, clear_req, clear_color,
    output rd_req, rd_x, rd_y,
    input  rd_valid, rd_color, busy, plot_count, drop_count, state_dbg
  );

  modport slave (
    input  VGA_X, VGA_Y, VGA_COLOR, plot, clear_req, clear_color,
    input  rd_req, rd_x, rd_y,
    output rd_valid, rd_color, busy, plot_count, drop_count, state_dbg
  );

endinterface

// File: rtl/vga_fb_ram.sv
// Simple dual-port frame store: one synchronous write port, one synchronous
// read port with one cycle of latency. A read and write to the same address
// on the same edge returns the previous contents.
module vga_fb_ram #(
  parameter int DEPTH = 19200,
  parameter int DW    = 3,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port and registered read port share one block so the read samples
  // the pre-edge contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/vga_plot_framebuffer.sv
// Receiving end of the pixel-plot bus: registers plot requests, filters out
// off-screen and busy-time plots, runs a full-frame clear engine, serves
// pipelined reads and keeps saturating accepted/dropped plot counters.
module vga_plot_framebuffer
  import vga_fb_pkg::*;
#(
  parameter int WIDTH      = FB_WIDTH,
  parameter int HEIGHT     = FB_HEIGHT,
  parameter int COLOR_BITS = 3,
  parameter bit PLOT_EDGE  = 1'b1
) (
  input logic                   CLOCK_50,
  input logic                   reset,
  vga_plot_framebuffer_if.slave bus
);

  localparam int                PIXELS    = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  localparam logic [X_W:0]      X_LIM     = (X_W + 1)'(WIDTH);
  localparam logic [Y_W:0]      Y_LIM     = (Y_W + 1)'(HEIGHT);

  // ---------------------------------------------------------------------
  // Plot input stage
  // ---------------------------------------------------------------------
  logic [X_W-1:0]        q1_x;
  logic [Y_W-1:0]        q1_y;
  logic [COLOR_BITS-1:0] q1_color;
  logic                  q1_plot;
  logic                  q2_plot;

  // Register the plot bus once; the extra plot tap feeds the edge detector.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      q1_x     <= '0;
      q1_y     <= '0;
      q1_color <= '0;
      q1_plot  <= 1'b0;
      q2_plot  <= 1'b0;
    end else begin
      q1_x     <= bus.VGA_X;
      q1_y     <= bus.VGA_Y;
      q1_color <= bus.VGA_COLOR;
      q1_plot  <= bus.plot;
      q2_plot  <= q1_plot;
    end
  end

  logic              wr_event;
  logic              plot_in_range;
  logic [ADDR_W-1:0] plot_addr;

  assign wr_event      = PLOT_EDGE ? (q1_plot & ~q2_plot) : q1_plot;
  assign plot_in_range = ({1'b0, q1_x} < X_LIM) && ({1'b0, q1_y} < Y_LIM);
  assign plot_addr     = ADDR_W'(q1_y) * ADDR_W'(WIDTH) + ADDR_W'(q1_x);

  // ---------------------------------------------------------------------
  // Clear engine FSM
  // ---------------------------------------------------------------------
  fb_state_t             state_q, state_d;
  logic [ADDR_W-1:0]     clr_addr_q, clr_addr_d;
  logic [COLOR_BITS-1:0] fill_q, fill_d;
  logic                  busy;

  // Reset lands in CLEAR with colour 0 so memory is defined after power-up.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      fill_q     <= fill_d;
    end
  end

  // IDLE waits for clear_req; CLEAR writes every address exactly once.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    fill_d     = fill_q;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
          fill_d     = bus.clear_color;
        end
      end
      CLEAR: begin
        busy       = 1'b1;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Write port arbitration and counters
  // ---------------------------------------------------------------------
  logic                  plot_ok;
  logic                  plot_drop;
  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_waddr;
  logic [COLOR_BITS-1:0] ram_wdata;

  assign plot_ok   = wr_event & plot_in_range & ~busy;
  assign plot_drop = wr_event & (busy | ~plot_in_range);

  // The clear engine owns the write port for the whole sweep.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = plot_addr;
    ram_wdata = q1_color;
    if (busy) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = fill_q;
    end else if (plot_ok) begin
      ram_we    = 1'b1;
    end
  end

  logic [15:0] plot_count_q;
  logic [7:0]  drop_count_q;

  // Accepted and rejected plot counters, both stick at all-ones.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      plot_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      if (plot_ok) begin
        plot_count_q <= sat_inc16(plot_count_q);
      end
      if (plot_drop) begin
        drop_count_q <= sat_inc8(drop_count_q);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------
  logic                  rd_in_range;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  ram_re;
  logic [COLOR_BITS-1:0] ram_rdata;
  logic                  rd_s1_valid;
  logic                  rd_s1_oor;
  logic                  rd_valid_q;
  logic [COLOR_BITS-1:0] rd_color_q;

  assign rd_in_range = ({1'b0, bus.rd_x} < X_LIM) && ({1'b0, bus.rd_y} < Y_LIM);
  assign rd_addr     = ADDR_W'(bus.rd_y) * ADDR_W'(WIDTH) + ADDR_W'(bus.rd_x);
  assign ram_re      = bus.rd_req & rd_in_range;

  // Stage 1 tracks the request alongside the RAM access; off-screen reads
  // skip the RAM and are answered with colour 0.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rd_s1_valid <= 1'b0;
      rd_s1_oor   <= 1'b0;
    end else begin
      rd_s1_valid <= bus.rd_req;
      rd_s1_oor   <= ~rd_in_range;
    end
  end

  // Stage 2 presents the colour for one cycle and holds it afterwards.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_color_q <= '0;
    end else begin
      rd_valid_q <= rd_s1_valid;
      if (rd_s1_valid) begin
        rd_color_q <= rd_s1_oor ? '0 : ram_rdata;
      end
    end
  end

  vga_fb_ram #(
    .DEPTH (PIXELS),
    .DW    (COLOR_BITS),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (CLOCK_50),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_color   = rd_color_q;
  assign bus.busy       = busy;
  assign bus.plot_count = plot_count_q;
  assign bus.drop_count = drop_count_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_vga_plot_framebuffer.sv
// Bench for vga_plot_framebuffer: one edge-mode and one level-mode instance,
// table-driven plot vectors plus hand-written clear/collision/reset sequences.
module tb_vga_plot_framebuffer;
  import vga_fb_pkg::*;

  localparam int CB    = 3;
  localparam int SWEEP = FB_PIXELS;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vga_plot_framebuffer_if #(.COLOR_BITS(CB)) bus0 ();
  vga_plot_framebuffer_if #(.COLOR_BITS(CB)) bus1 ();

  vga_plot_framebuffer #(
    .WIDTH(FB_WIDTH), .HEIGHT(FB_HEIGHT), .COLOR_BITS(CB), .PLOT_EDGE(1'b1)
  ) dut0 (.CLOCK_50(clk), .reset(rst), .bus(bus0));

  vga_plot_framebuffer #(
    .WIDTH(FB_WIDTH), .HEIGHT(FB_HEIGHT), .COLOR_BITS(CB), .PLOT_EDGE(1'b0)
  ) dut1 (.CLOCK_50(clk), .reset(rst), .bus(bus1));

  // Scoreboard state
  int checks   = 0;
  int failures = 0;
  logic [CB-1:0] exp_q0[$];
  logic [CB-1:0] exp_q1[$];
  int exp_cyc_q0[$];
  int exp_cyc_q1[$];

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Read monitor for dut0: each rd_valid pops one expectation.
  always @(negedge clk) begin
    if (bus0.rd_valid === 1'b1) begin
      if (exp_q0.size() == 0) fail_now("rd0_unexpected_valid");
      else begin
        check("rd0_color", int'(bus0.rd_color), int'(exp_q0.pop_front()));
        check("rd0_latency", cyc, exp_cyc_q0.pop_front());
      end
    end else if (exp_cyc_q0.size() != 0 && cyc >= exp_cyc_q0[0]) begin
      fail_now("rd0_missing_valid");
      void'(exp_q0.pop_front());
      void'(exp_cyc_q0.pop_front());
    end
  end

  // Read monitor for dut1.
  always @(negedge clk) begin
    if (bus1.rd_valid === 1'b1) begin
      if (exp_q1.size() == 0) fail_now("rd1_unexpected_valid");
      else begin
        check("rd1_color", int'(bus1.rd_color), int'(exp_q1.pop_front()));
        check("rd1_latency", cyc, exp_cyc_q1.pop_front());
      end
    end else if (exp_cyc_q1.size() != 0 && cyc >= exp_cyc_q1[0]) begin
      fail_now("rd1_missing_valid");
      void'(exp_q1.pop_front());
      void'(exp_cyc_q1.pop_front());
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    repeat (n) tick();
  endtask

  task automatic rd(input int sel, input int x, input int y, input logic [CB-1:0] exp_v);
    if (sel == 0) begin
      bus0.rd_req = 1'b1; bus0.rd_x = 8'(x); bus0.rd_y = 7'(y);
      exp_q0.push_back(exp_v); exp_cyc_q0.push_back(cyc + 2);
    end else begin
      bus1.rd_req = 1'b1; bus1.rd_x = 8'(x); bus1.rd_y = 7'(y);
      exp_q1.push_back(exp_v); exp_cyc_q1.push_back(cyc + 2);
    end
    tick();
    bus0.rd_req = 1'b0;
    bus1.rd_req = 1'b0;
  endtask

  task automatic drain(input int sel);
    int n = 0;
    while (((sel == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < 20) begin
      tick();
      n++;
    end
    check((sel == 0) ? "rd0_drain" : "rd1_drain",
          (sel == 0) ? exp_q0.size() : exp_q1.size(), 0);
  endtask

  task automatic plot_pulse0(input int x, input int y, input logic [CB-1:0] c);
    bus0.VGA_X = 8'(x); bus0.VGA_Y = 7'(y); bus0.VGA_COLOR = c;
    bus0.plot = 1'b1;
    tick();
    bus0.plot = 1'b0;
    tickn(2);
  endtask

  // Counts cycles busy stays high, bounded; returns the count.
  task automatic count_busy(output int n);
    n = 0;
    while (bus0.busy === 1'b1 && n < SWEEP + 100) begin
      n++;
      tick();
    end
  endtask

  typedef struct {
    int          x;
    int          y;
    logic [CB-1:0] color;
    bit          accept;
  } plot_vec_t;

  plot_vec_t vecs[6];

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_plot0;
    int exp_drop0;
    logic [CB-1:0] last_rd;

    vecs[0] = '{x: 5,   y: 3,   color: 3'd6, accept: 1'b1};
    vecs[1] = '{x: 160, y: 0,   color: 3'd1, accept: 1'b0};
    vecs[2] = '{x: 0,   y: 120, color: 3'd2, accept: 1'b0};
    vecs[3] = '{x: 255, y: 127, color: 3'd4, accept: 1'b0};
    vecs[4] = '{x: 159, y: 119, color: 3'd7, accept: 1'b1};
    vecs[5] = '{x: 0,   y: 0,   color: 3'd3, accept: 1'b1};
    exp_plot0 = 0;
    exp_drop0 = 0;
    last_rd   = '0;

    bus0.VGA_X = '0; bus0.VGA_Y = '0; bus0.VGA_COLOR = '0; bus0.plot = 1'b0;
    bus0.clear_req = 1'b0; bus0.clear_color = '0;
    bus0.rd_req = 1'b0; bus0.rd_x = '0; bus0.rd_y = '0;
    bus1.VGA_X = '0; bus1.VGA_Y = '0; bus1.VGA_COLOR = '0; bus1.plot = 1'b0;
    bus1.clear_req = 1'b0; bus1.clear_color = '0;
    bus1.rd_req = 1'b0; bus1.rd_x = '0; bus1.rd_y = '0;

    // Reset values and the post-reset sweep
    rst = 1'b1;
    tickn(3);
    check("reset_busy", int'(bus0.busy), 1);
    check("reset_state", int'(bus0.state_dbg), int'(CLEAR));
    check("reset_rd_valid", int'(bus0.rd_valid), 0);
    check("reset_rd_color", int'(bus0.rd_color), 0);
    check("reset_plot_count", int'(bus0.plot_count), 0);
    check("reset_drop_count", int'(bus0.drop_count), 0);
    rst = 1'b0;
    count_busy(n);
    check("init_sweep_cycles", n, SWEEP);
    check("init_dut1_idle", int'(bus1.busy), 0);
    rd(0, 0, 0, 3'd0);
    rd(0, 159, 119, 3'd0);
    drain(0);

    // Table-driven single plots: in-range writes, off-screen drops
    for (int i = 0; i < 6; i++) begin
      plot_pulse0(vecs[i].x, vecs[i].y, vecs[i].color);
      if (vecs[i].accept) exp_plot0++;
      else exp_drop0++;
      check("vec_plot_count", int'(bus0.plot_count), exp_plot0);
      check("vec_drop_count", int'(bus0.drop_count), exp_drop0);
      last_rd = vecs[i].accept ? vecs[i].color : 3'd0;
      rd(0, vecs[i].x, vecs[i].y, last_rd);
    end
    drain(0);
    tickn(3);
    check("rd_color_hold", int'(bus0.rd_color), int'(last_rd));
    check("rd_valid_idle", int'(bus0.rd_valid), 0);
    rd(0, 200, 5, 3'd0);
    drain(0);

    // Plot held high for 10 cycles: one write in edge mode, ten in level mode
    for (int i = 0; i < 10; i++) begin
      bus0.VGA_X = 8'(10 + i); bus0.VGA_Y = 7'd30; bus0.VGA_COLOR = 3'(1 + i % 7);
      bus1.VGA_X = 8'(10 + i); bus1.VGA_Y = 7'd20; bus1.VGA_COLOR = 3'(1 + i % 7);
      bus0.plot = 1'b1;
      bus1.plot = 1'b1;
      tick();
    end
    bus0.plot = 1'b0;
    bus1.plot = 1'b0;
    tickn(2);
    exp_plot0++;
    check("edge_plot_count", int'(bus0.plot_count), exp_plot0);
    check("level_plot_count", int'(bus1.plot_count), 10);
    check("level_drop_count", int'(bus1.drop_count), 0);
    rd(0, 10, 30, 3'd1);
    rd(0, 11, 30, 3'd0);
    rd(0, 19, 30, 3'd0);
    for (int i = 0; i < 10; i++) rd(1, 10 + i, 20, 3'(1 + i % 7));
    drain(0);
    drain(1);

    // Level mode, off-screen plot held long enough to saturate drop_count
    bus1.VGA_X = 8'd200; bus1.VGA_Y = 7'd0; bus1.plot = 1'b1;
    tickn(260);
    bus1.plot = 1'b0;
    tickn(2);
    check("drop_saturate", int'(bus1.drop_count), 255);
    check("drop_sat_plot_count", int'(bus1.plot_count), 10);

    // Commanded clear with plots and a second clear_req mid-sweep
    bus0.clear_color = 3'd5; bus0.clear_req = 1'b1;
    tick();
    bus0.clear_req = 1'b0; bus0.clear_color = 3'd0;
    bus0.VGA_X = 8'd1; bus0.VGA_Y = 7'd1; bus0.VGA_COLOR = 3'd7;
    n = 0;
    while (bus0.busy === 1'b1 && n < SWEEP + 100) begin
      bus0.plot      = (n == 100 || n == 300 || n == 5000);
      bus0.clear_req = (n == 200);
      bus0.clear_color = (n == 200) ? 3'd2 : 3'd0;
      bus0.rd_req    = 1'b0;
      if (n == 400) begin
        bus0.rd_req = 1'b1; bus0.rd_x = 8'd0; bus0.rd_y = 7'd0;
        exp_q0.push_back(3'd5); exp_cyc_q0.push_back(cyc + 2);
      end
      n++;
      tick();
    end
    bus0.plot = 1'b0; bus0.clear_req = 1'b0; bus0.rd_req = 1'b0;
    exp_drop0 += 3;
    check("clear_sweep_cycles", n, SWEEP);
    check("clear_drop_count", int'(bus0.drop_count), exp_drop0);
    check("clear_plot_count", int'(bus0.plot_count), exp_plot0);
    rd(0, 1, 1, 3'd5);
    rd(0, 5, 3, 3'd5);
    rd(0, 159, 119, 3'd5);
    rd(0, 0, 0, 3'd5);
    for (int i = 0; i < 16; i++) rd(0, $urandom_range(0, 159), $urandom_range(0, 119), 3'd5);
    drain(0);

    // Read-before-write collision at (7,7)
    plot_pulse0(7, 7, 3'd2);
    exp_plot0++;
    rd(0, 7, 7, 3'd2);
    drain(0);
    bus0.VGA_X = 8'd7; bus0.VGA_Y = 7'd7; bus0.VGA_COLOR = 3'd4; bus0.plot = 1'b1;
    tick();
    bus0.plot = 1'b0;
    rd(0, 7, 7, 3'd2);
    rd(0, 7, 7, 3'd4);
    drain(0);
    exp_plot0++;
    check("collision_plot_count", int'(bus0.plot_count), exp_plot0);

    // Reset in the middle of a sweep restarts it with colour 0
    bus0.clear_color = 3'd6; bus0.clear_req = 1'b1;
    tick();
    bus0.clear_req = 1'b0;
    tickn(1000);
    rst = 1'b1;
    tickn(2);
    check("midreset_busy", int'(bus0.busy), 1);
    check("midreset_plot_count", int'(bus0.plot_count), 0);
    check("midreset_drop_count", int'(bus0.drop_count), 0);
    check("midreset_rd_color", int'(bus0.rd_color), 0);
    rst = 1'b0;
    count_busy(n);
    check("midreset_sweep_cycles", n, SWEEP);
    rd(0, 7, 7, 3'd0);
    rd(0, 100, 100, 3'd0);
    rd(0, 0, 0, 3'd0);
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
